// File: rtl/wasm_pkg.sv
// Shared definitions for the WASM stack core: opcodes, FSM states, fault codes
// and the per-opcode stack effect table.
// Optional feature macro: WASM_MUL_EN (decodes 0x6C mul as a binary op).
package wasm_pkg;

    localparam logic [7:0] OpUnreachable = 8'h00;
    localparam logic [7:0] OpNop         = 8'h01;
    localparam logic [7:0] OpEnd         = 8'h0B;
    localparam logic [7:0] OpDrop        = 8'h1A;
    localparam logic [7:0] OpConst       = 8'h41;
    localparam logic [7:0] OpEqz         = 8'h45;
    localparam logic [7:0] OpEq          = 8'h46;
    localparam logic [7:0] OpLtU         = 8'h49;
    localparam logic [7:0] OpAdd         = 8'h6A;
    localparam logic [7:0] OpSub         = 8'h6B;
    localparam logic [7:0] OpMul         = 8'h6C;
    localparam logic [7:0] OpAnd         = 8'h71;
    localparam logic [7:0] OpOr          = 8'h72;
    localparam logic [7:0] OpXor         = 8'h73;

    localparam logic [2:0] FaultEnd       = 3'd0;
    localparam logic [2:0] FaultOverflow  = 3'd1;
    localparam logic [2:0] FaultUnderflow = 3'd2;
    localparam logic [2:0] FaultIllegal   = 3'd3;
    localparam logic [2:0] FaultLebLong   = 3'd4;
    localparam logic [2:0] FaultTrap      = 3'd5;

    typedef enum logic [2:0] {StIdle, StFetch, StImm, StExec, StHalt} state_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] pops;
        logic [1:0] pushes;
    } op_info_t;

    // Stack effect of each opcode; legal=0 marks opcodes outside the supported set.
    function automatic op_info_t op_info(input logic [7:0] op);
        op_info_t info;
        info.legal  = 1'b1;
        info.pops   = 2'd0;
        info.pushes = 2'd0;
        case (op)
            OpUnreachable, OpNop, OpEnd: begin end
            OpDrop:  info.pops = 2'd1;
            OpConst: info.pushes = 2'd1;
            OpEqz: begin
                info.pops   = 2'd1;
                info.pushes = 2'd1;
            end
            OpEq, OpLtU, OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
                info.pops   = 2'd2;
                info.pushes = 2'd1;
            end
`ifdef WASM_MUL_EN
            OpMul: begin
                info.pops   = 2'd2;
                info.pushes = 2'd1;
            end
`endif
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/wasm_leb_decoder.sv
// Signed LEB128 immediate decoder. Accumulates 7-bit groups per valid byte,
// flags the final byte (done) or an over-long encoding (error), and holds the
// sign-extended, DATA_W-truncated value after done.
module wasm_leb_decoder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_LEB = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [7:0]        byte_in,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] value
);

    localparam int unsigned AccW = (7 * MAX_LEB > DATA_W) ? 7 * MAX_LEB : DATA_W;
    localparam int unsigned CntW = $clog2(MAX_LEB + 1);

    logic [AccW-1:0]   acc_q, acc_d, acc_sum, low_mask;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              last_slot;

    // Accumulate payload groups; finalise with sign extension on the terminating byte.
    always_comb begin
        acc_sum   = acc_q | (AccW'(byte_in[6:0]) << (7 * cnt_q));
        // Bits below the final group; a shift of AccW yields 0 and so an all-ones mask.
        low_mask  = (AccW'(1) << (7 * (cnt_q + 1))) - AccW'(1);
        last_slot = (32'(cnt_q) == MAX_LEB - 1);
        done      = valid && !byte_in[7];
        error     = valid && byte_in[7] && last_slot;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (valid) begin
            if (byte_in[7]) begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end else begin
                value_d = DATA_W'(byte_in[6] ? (acc_sum | ~low_mask) : acc_sum);
            end
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/wasm_stack_core.sv
// Byte-serial WASM interpreter core with an internal operand stack register file.
// Optional feature macro: WASM_MUL_EN (adds the 0x6C mul binary op).
module wasm_stack_core import wasm_pkg::*; #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAX_LEB     = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rom_mapped,
    input  logic [ADDR_W-1:0]            first_instruction,
    output logic [ADDR_W-1:0]            addr,
    output logic                         memory_read_en,
    input  logic [7:0]                   data_out,
    input  logic                         memory_ready,
    output logic                         halted,
    output logic [2:0]                   fault,
    output logic [DATA_W-1:0]            tos,
    output logic [$clog2(STACK_DEPTH):0] depth
);

    localparam int unsigned DepW = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IdxW = $clog2(STACK_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              rd_en_q, rd_en_d;
    logic              need_low_q, need_low_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [2:0]        fault_q, fault_d;
    logic [DepW-1:0]   depth_q, depth_d;
    logic [DATA_W-1:0] stack_q [STACK_DEPTH];

    logic              wr_en;
    logic [IdxW-1:0]   wr_idx;
    logic [DATA_W-1:0] wr_data, op_a, op_b, result;
    logic [DepW:0]     depth_after;
    logic              xfer, req_ok;
    logic              leb_clear, leb_valid, leb_done, leb_error;
    logic [DATA_W-1:0] leb_value;
    op_info_t          info;

    wasm_leb_decoder #(
        .DATA_W  (DATA_W),
        .MAX_LEB (MAX_LEB)
    ) u_leb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (leb_clear),
        .valid   (leb_valid),
        .byte_in (data_out),
        .done    (leb_done),
        .error   (leb_error),
        .value   (leb_value)
    );

    // Operands, stack effect and ALU result for the instruction in EXEC.
    always_comb begin
        info        = op_info((state_q == StExec) ? opcode_q : data_out);
        op_b        = stack_q[IdxW'(depth_q - DepW'(1))];
        op_a        = stack_q[IdxW'(depth_q - DepW'(2))];
        depth_after = (DepW + 1)'(depth_q) - (DepW + 1)'(info.pops) + (DepW + 1)'(info.pushes);
        case (opcode_q)
            OpConst: result = leb_value;
            OpEqz:   result = DATA_W'(op_b == '0);
            OpEq:    result = DATA_W'(op_a == op_b);
            OpLtU:   result = DATA_W'(op_a < op_b);
            OpAdd:   result = op_a + op_b;
            OpSub:   result = op_a - op_b;
            OpAnd:   result = op_a & op_b;
            OpOr:    result = op_a | op_b;
            OpXor:   result = op_a ^ op_b;
`ifdef WASM_MUL_EN
            OpMul:   result = op_a * op_b;
`endif
            default: result = '0;
        endcase
    end

    // Next-state logic: fetch handshake, immediate decode, bounds-checked execute.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        fault_d    = fault_q;
        depth_d    = depth_q;
        rd_en_d    = 1'b0;
        xfer       = rd_en_q && memory_ready;
        // A new request waits until ready has been seen low after the last transfer.
        req_ok     = !need_low_q || !memory_ready;
        need_low_d = need_low_q && memory_ready;
        leb_clear  = (state_q == StFetch);
        leb_valid  = (state_q == StImm) && xfer;
        wr_en      = 1'b0;
        wr_idx     = IdxW'(depth_after - (DepW + 1)'(1));
        wr_data    = result;

        if (state_q == StFetch || state_q == StImm) begin
            if (xfer) begin
                need_low_d = 1'b1;
                pc_d       = pc_q + 1'b1;
            end else begin
                rd_en_d = rd_en_q || req_ok;
            end
        end

        case (state_q)
            StIdle: begin
                if (rom_mapped) begin
                    pc_d    = first_instruction;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (xfer) begin
                    opcode_d = data_out;
                    if (!info.legal) begin
                        fault_d = FaultIllegal;
                        state_d = StHalt;
                    end else if (data_out == OpConst) begin
                        state_d = StImm;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StImm: begin
                if (leb_error) begin
                    fault_d = FaultLebLong;
                    state_d = StHalt;
                end else if (leb_done) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                if (DepW'(info.pops) > depth_q) begin
                    fault_d = FaultUnderflow;
                    state_d = StHalt;
                end else if (depth_after > (DepW + 1)'(STACK_DEPTH)) begin
                    fault_d = FaultOverflow;
                    state_d = StHalt;
                end else begin
                    depth_d = DepW'(depth_after);
                    wr_en   = (info.pushes != 2'd0);
                    if (opcode_q == OpEnd) begin
                        fault_d = FaultEnd;
                        state_d = StHalt;
                    end else if (opcode_q == OpUnreachable) begin
                        fault_d = FaultTrap;
                        state_d = StHalt;
                    end
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // Control state; reset drops the fetch request asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            rd_en_q    <= 1'b0;
            need_low_q <= 1'b0;
            opcode_q   <= 8'h00;
            fault_q    <= FaultEnd;
            depth_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_en_q    <= rd_en_d;
            need_low_q <= need_low_d;
            opcode_q   <= opcode_d;
            fault_q    <= fault_d;
            depth_q    <= depth_d;
        end
    end

    // Operand stack storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= wr_data;
        end
    end

    assign addr           = pc_q;
    assign memory_read_en = rd_en_q;
    assign halted         = (state_q == StHalt);
    assign fault          = fault_q;
    assign depth          = depth_q;
    assign tos            = (depth_q == '0) ? '0 : op_b;

endmodule

// File: tb/tb_wasm_stack_core.sv
// Self-checking bench for wasm_stack_core: directed programs plus random programs
// compared against a queue-based interpreter model; memory answers with random latency.
module tb_wasm_stack_core;

    localparam int unsigned DataW      = 32;
    localparam int unsigned StackDepth = 4;
    localparam int unsigned AddrW      = 32;
    localparam int unsigned MaxLeb     = 5;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          rom_mapped;
    logic [AddrW-1:0]              first_instruction;
    logic [AddrW-1:0]              addr;
    logic                          memory_read_en;
    logic [7:0]                    data_out;
    logic                          memory_ready;
    logic                          halted;
    logic [2:0]                    fault;
    logic [DataW-1:0]              tos;
    logic [$clog2(StackDepth):0]   depth;

    always #5 clk = ~clk;

    wasm_stack_core #(
        .DATA_W      (DataW),
        .STACK_DEPTH (StackDepth),
        .ADDR_W      (AddrW),
        .MAX_LEB     (MaxLeb)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rom_mapped        (rom_mapped),
        .first_instruction (first_instruction),
        .addr              (addr),
        .memory_read_en    (memory_read_en),
        .data_out          (data_out),
        .memory_ready      (memory_ready),
        .halted            (halted),
        .fault             (fault),
        .tos               (tos),
        .depth             (depth)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] mem [256];
    logic [7:0] prog_q[$];
    int wait_cnt  = 0;
    int transfers = 0;
    logic [AddrW-1:0] last_addr = '0;
    logic last_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One memory-side cycle, driven at the falling edge.
    task automatic mem_step(input bit respond);
        @(negedge clk);
        if (last_en && memory_read_en) check("addr_stable", addr, last_addr);
        if (memory_ready) begin
            check("req_drop_after_xfer", memory_read_en, 1'b0);
            memory_ready = 1'b0;
            wait_cnt     = $urandom_range(0, 3);
        end else if (memory_read_en && respond) begin
            if (wait_cnt == 0) begin
                memory_ready = 1'b1;
                data_out     = mem[addr[7:0]];
                transfers++;
            end else begin
                wait_cnt--;
            end
        end
        last_en   = memory_read_en;
        last_addr = addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        rom_mapped   = 1'b0;
        memory_ready = 1'b0;
        data_out     = 8'h00;
        wait_cnt     = 0;
        last_en      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 3'd0);
        check("rst_read_en", memory_read_en, 1'b0);
        check("rst_addr", addr, '0);
        check("rst_depth", depth, '0);
        check("rst_tos", tos, '0);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [AddrW-1:0] start);
        for (int i = 0; i < 256; i++) mem[i] = 8'h0B;
        for (int i = 0; i < prog_q.size(); i++) mem[(start + i) & 255] = prog_q[i];
        first_instruction = start;
    endtask

    task automatic run();
        bit done_ok = 1'b0;
        rom_mapped = 1'b1;
        for (int cyc = 0; cyc < 3000 && !done_ok; cyc++) begin
            mem_step(1'b1);
            if (halted) done_ok = 1'b1;
        end
        check("halt_reached", done_ok, 1'b1);
        @(negedge clk);
        check("halt_no_req", memory_read_en, 1'b0);
    endtask

    task automatic run_expect(input string tag, input logic [2:0] f, input logic [31:0] t,
                              input int d);
        run();
        check({tag, "_fault"}, fault, f);
        check({tag, "_tos"}, tos, t);
        check({tag, "_depth"}, depth, d);
        check({tag, "_halted"}, halted, 1'b1);
    endtask

    // Interpreter model: executes bytes from mem with a queue as the operand stack.
    task automatic model(input logic [AddrW-1:0] start, output logic [2:0] f,
                         output logic [31:0] t, output int d);
        logic [31:0] stk[$];
        logic [31:0] pc = start;
        logic [31:0] a, b, imm, res;
        logic [63:0] acc;
        logic [7:0]  op, byt;
        int pops, pushes, n;
        bit stop = 1'b0, legal, leb_fin;
        f = 3'd0;
        for (int step = 0; step < 1000 && !stop; step++) begin
            op = mem[pc[7:0]];
            pc++;
            legal = 1'b1;
            pops = 0;
            pushes = 0;
            case (op)
                8'h00, 8'h01, 8'h0B: ;
                8'h1A: pops = 1;
                8'h41: pushes = 1;
                8'h45: begin pops = 1; pushes = 1; end
                8'h46, 8'h49, 8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: begin pops = 2; pushes = 1; end
`ifdef WASM_MUL_EN
                8'h6C: begin pops = 2; pushes = 1; end
`endif
                default: legal = 1'b0;
            endcase
            if (!legal) begin
                f = 3'd3;
                stop = 1'b1;
            end
            if (!stop && op == 8'h41) begin
                acc = 64'd0;
                n = 0;
                leb_fin = 1'b0;
                while (!leb_fin && !stop) begin
                    byt = mem[pc[7:0]];
                    pc++;
                    acc = acc | (64'(byt & 8'h7F) << (7 * n));
                    if (byt[7]) begin
                        n++;
                        if (n == MaxLeb) begin
                            f = 3'd4;
                            stop = 1'b1;
                        end
                    end else begin
                        if (byt[6]) acc = acc | (~64'd0 << (7 * n + 7));
                        leb_fin = 1'b1;
                    end
                end
                imm = acc[31:0];
            end
            if (!stop && stk.size() < pops) begin
                f = 3'd2;
                stop = 1'b1;
            end
            if (!stop && stk.size() - pops + pushes > StackDepth) begin
                f = 3'd1;
                stop = 1'b1;
            end
            if (!stop) begin
                b = 32'd0;
                a = 32'd0;
                if (pops >= 1) b = stk.pop_back();
                if (pops == 2) a = stk.pop_back();
                case (op)
                    8'h41: res = imm;
                    8'h45: res = (b == 0) ? 32'd1 : 32'd0;
                    8'h46: res = (a == b) ? 32'd1 : 32'd0;
                    8'h49: res = (a < b) ? 32'd1 : 32'd0;
                    8'h6A: res = a + b;
                    8'h6B: res = a - b;
                    8'h6C: res = a * b;
                    8'h71: res = a & b;
                    8'h72: res = a | b;
                    8'h73: res = a ^ b;
                    default: res = 32'd0;
                endcase
                if (pushes == 1) stk.push_back(res);
                if (op == 8'h0B) begin
                    f = 3'd0;
                    stop = 1'b1;
                end
                if (op == 8'h00) begin
                    f = 3'd5;
                    stop = 1'b1;
                end
            end
        end
        d = stk.size();
        t = (d == 0) ? 32'd0 : stk[d-1];
    endtask

    task automatic gen_prog();
        int n, r, nb;
        logic [7:0] bin_ops[7];
        logic [7:0] misc_ops[3];
        bin_ops  = '{8'h46, 8'h49, 8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73};
        misc_ops = '{8'h45, 8'h1A, 8'h01};
        prog_q.delete();
        n = $urandom_range(3, 14);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                prog_q.push_back(8'h41);
                nb = ($urandom_range(0, 19) == 0) ? 6 : $urandom_range(1, 3);
                for (int k = 0; k < nb; k++)
                    prog_q.push_back(8'($urandom_range(0, 127)) | ((k < nb - 1) ? 8'h80 : 8'h00));
            end else if (r < 75) begin
                prog_q.push_back(bin_ops[$urandom_range(0, 6)]);
            end else if (r < 95) begin
                prog_q.push_back(misc_ops[$urandom_range(0, 2)]);
            end else if (r < 97) begin
                prog_q.push_back(8'h00);
            end else begin
                prog_q.push_back(8'($urandom_range(0, 255)));
            end
        end
        prog_q.push_back(8'h0B);
    endtask

    initial begin
        logic [2:0]  mf;
        logic [31:0] mt;
        int          md;
        logic [AddrW-1:0] start;
        bit          got_req;

        rst_n             = 1'b0;
        rom_mapped        = 1'b0;
        memory_ready      = 1'b0;
        data_out          = 8'h00;
        first_instruction = '0;

        do_reset();
        prog_q = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h0B};
        load(32'd16);
        run_expect("add", 3'd0, 32'd8, 1);

        do_reset();
        prog_q = '{8'h41, 8'h7F, 8'h0B};
        load(32'd200);
        run_expect("neg_one", 3'd0, 32'hFFFF_FFFF, 1);

        do_reset();
        prog_q = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        load(32'd3);
        run_expect("leb_long", 3'd4, 32'd0, 0);

        do_reset();
        prog_q = '{8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01};
        load(32'd250);
        run_expect("overflow", 3'd1, 32'd1, 4);

        do_reset();
        prog_q = '{8'h6A};
        load(32'd0);
        run_expect("underflow", 3'd2, 32'd0, 0);

        do_reset();
        prog_q = '{8'h41, 8'h06, 8'h41, 8'h07, 8'h6C, 8'h0B};
        load(32'd64);
`ifdef WASM_MUL_EN
        run_expect("mul", 3'd0, 32'd42, 1);
`else
        run_expect("mul_illegal", 3'd3, 32'd7, 2);
`endif

        do_reset();
        prog_q = '{8'h41, 8'h2A, 8'h00, 8'h41, 8'h01};
        load(32'd90);
        run_expect("unreachable", 3'd5, 32'd42, 1);

        // Stall mid-immediate, then reset while the request is outstanding.
        do_reset();
        prog_q = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h01, 8'h0B};
        load(32'd40);
        rom_mapped = 1'b1;
        transfers  = 0;
        for (int cyc = 0; cyc < 200 && transfers < 2; cyc++) mem_step(1'b1);
        repeat (10) mem_step(1'b0);
        check("stall_req_held", memory_read_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", memory_read_en, 1'b0);
        check("async_addr_zero", addr, '0);
        @(negedge clk);
        memory_ready = 1'b0;
        wait_cnt     = 0;
        last_en      = 1'b0;
        prog_q = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h0B};
        load(32'd120);
        rst_n      = 1'b1;
        rom_mapped = 1'b1;
        got_req    = 1'b0;
        for (int cyc = 0; cyc < 20 && !got_req; cyc++) begin
            @(negedge clk);
            if (memory_read_en) got_req = 1'b1;
        end
        check("restart_req", got_req, 1'b1);
        check("restart_addr", addr, 32'd120);
        run_expect("restart", 3'd0, 32'd8, 1);

        // Random programs against the interpreter model.
        for (int p = 0; p < 60; p++) begin
            do_reset();
            gen_prog();
            start = AddrW'($urandom_range(0, 255));
            load(start);
            model(start, mf, mt, md);
            run_expect($sformatf("rand%0d", p), mf, mt, md);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wasm_stack_core.md
Name: wasm_stack_core

Overview:
- Parametrised successor to the single-width WASM interpreter CPU.
- Executes a straight-line WASM instruction subset fetched byte-serially from the shared memory bus.
- Holds the operand stack in an internal register file of configurable depth and width, instead of spilling it to memory.
- Decodes signed LEB128 immediates, performs stack-bounds checking and reports halt/fault status to the platform.

Parameters:
DATA_W, 32, operand width in bits (32 or 64); arithmetic wraps modulo 2^DATA_W.
STACK_DEPTH, 16, operand stack entries (power of two, 2..256).
ADDR_W, 32, instruction address width.
MAX_LEB, 5, maximum immediate bytes; ceil(DATA_W/7) is the minimum legal value.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rom_mapped  in  1  level; high means ROM is valid and execution may start
first_instruction  in  ADDR_W  start PC, sampled in IDLE when rom_mapped is high
addr  out  ADDR_W  fetch address
memory_read_en  out  1  fetch request
data_out  in  8  fetched byte, valid when memory_ready is high
memory_ready  in  1  fetch completion
halted  out  1  core stopped
fault  out  3  halt cause: 0 end, 1 overflow, 2 underflow, 3 illegal opcode, 4 LEB too long, 5 unreachable trap
tos  out  DATA_W  top-of-stack value; 0 when the stack is empty
depth  out  $clog2(STACK_DEPTH)+1  current entry count

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - Outputs on reset: halted=0, fault=0, memory_read_en=0, addr=0, depth=0, tos=0.
  - State goes to IDLE; stack contents are don't-care.
- Handshake:
  - Core raises memory_read_en with addr held stable.
  - A transfer completes in the first cycle where memory_read_en && memory_ready; data_out is captured in that cycle.
  - Core drops memory_read_en in the next cycle. It issues no new request until it has sampled memory_ready low.
- States: IDLE, FETCH, IMM, EXEC, HALT.
  - IDLE -> FETCH when rom_mapped is high; pc <= first_instruction.
  - FETCH: read byte at pc, pc <= pc+1, latch opcode.
    - Opcode takes an immediate (0x41) -> IMM.
    - Otherwise -> EXEC.
    - Opcode not in the set -> HALT with fault 3.
  - IMM: accumulate (byte&0x7F) << 7*n, pc increments per byte.
    - Continues while bit7 is set.
    - On the final byte: sign-extend from bit 7n+6 if that bit is set, truncate to DATA_W, go to EXEC.
    - Byte count reaching MAX_LEB with bit7 still set -> HALT with fault 4.
  - EXEC: single cycle, then -> FETCH unless halting.
- Opcode set:
  - 0x00 unreachable: fault 5.
  - 0x01 nop.
  - 0x0B end: halt with fault 0.
  - 0x1A drop: pop 1.
  - 0x41 const: push 1.
  - 0x45 eqz: pop 1, push 1.
  - 0x46 eq, 0x49 lt_u, 0x6A add, 0x6B sub, 0x71 and, 0x72 or, 0x73 xor: pop 2, push 1.
  - Binary operand order: a = second-from-top, b = top; result = a op b.
  - Compare results are 1 or 0, zero-extended.
- Bounds:
  - Check in EXEC before any write; a failing check leaves the stack unchanged and halts.
  - depth < pops -> fault 2.
  - depth - pops + pushes > STACK_DEPTH -> fault 1.
  - Filling exactly to STACK_DEPTH is legal.
- HALT: sticky until reset; memory_read_en=0; tos and depth remain observable.
- Reset mid-fetch: request drops immediately (asynchronously); the partial immediate is discarded.
- pc wraps modulo 2^ADDR_W silently.

Optional Feature:
- Macro: WASM_MUL_EN.
- Defined: 0x6C mul is decoded as a binary op producing the low DATA_W bits of the product, single-cycle.
- Undefined: 0x6C is illegal (fault 3) and no multiplier is synthesised.

Decomposition:
- Package wasm_pkg holds:
  - opcode localparams;
  - state encoding;
  - fault code constants;
  - helper function returning pop/push counts per opcode.
- One sub-module: wasm_leb_decoder.
  - Byte in, valid strobe.
  - Outputs: done, error, sign-extended DATA_W value.
  - Clear input from the core.
- The stack register file stays inline.

Test Plan:
- Bytes 41 05 41 03 6A 0B -> tos=8, depth=1, halted=1, fault=0.
- Bytes 41 7F 0B, DATA_W=32 -> tos=0xFFFFFFFF. With DATA_W=64 -> tos=0xFFFFFFFFFFFFFFFF.
- Bytes 41 80 80 80 80 80 with MAX_LEB=5 -> fault=4, depth=0.
- STACK_DEPTH=4, five "41 01" -> fault=1, depth=4 after the fourth push. Separately, byte 6A on an empty stack -> fault=2, depth=0.
- Byte 6C -> fault 3 without WASM_MUL_EN. With it, 41 06 41 07 6C 0B -> tos=42.
- Hold memory_ready low for 10 cycles mid-immediate, then assert rst_n=0 -> memory_read_en=0 in the same cycle. After release with rom_mapped=1, execution restarts cleanly at first_instruction.
